ahbl_splitter_burst: RTL and testbench
======================================

Name: ahbl_splitter_burst

Overview:
AHB-lite 1:N splitter with burst support, the parametrised successor to the existing single-beat splitter. Routes one master to N slave ports by address decode. Pins every beat of a burst to the slave that decoded its NONSEQ beat, so a burst that crosses a region boundary is never split. Generates the two-cycle AHB ERROR response for unmapped or unconnected addresses and records the last failing address for debug.

Parameters:
N_PORTS, 2, number of slave ports (1..16)
W_ADDR, 32, address width
W_DATA, 32, data width
ADDR_MAP, {N_PORTS{W_ADDR'h0}}, per-port match value; port i occupies bits [i*W_ADDR +: W_ADDR]
ADDR_MASK, {N_PORTS{W_ADDR'h0}}, per-port match mask, same packing as ADDR_MAP
CONN_MASK, {N_PORTS{1'b1}}, port i is reachable only if bit i is set
W_ERRCNT, 8, width of the saturating decode-error counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
src_hready  in  1  bus hready to the splitter's own slave port
src_hready_resp  out  1  hready response to the master
src_hresp  out  1  hresp to the master
src_haddr  in  W_ADDR  address
src_hwrite  in  1  write enable
src_htrans  in  2  transfer type
src_hsize  in  3  transfer size
src_hburst  in  3  burst type
src_hprot  in  4  protection control
src_hmastlock  in  1  locked transfer
src_hwdata  in  W_DATA  write data
src_hrdata  out  W_DATA  read data
dst_hready  out  N_PORTS  replicated src_hready
dst_hready_resp  in  N_PORTS  per-port hready response
dst_hresp  in  N_PORTS  per-port hresp
dst_haddr, dst_hwrite, dst_hsize, dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata  out  N_PORTS x field width  replicated source fields
dst_htrans  out  2*N_PORTS  per-port gated htrans
dst_hrdata  in  N_PORTS*W_DATA  per-port read data
err_count  out  W_ERRCNT  saturating count of decode errors
err_addr  out  W_ADDR  address of the most recent decode error
err_pulse  out  1  one-cycle pulse on the second ERROR cycle

Behaviour:
- The clock is clk. Reset is rst: synchronous, active-high.
- Decode (address phase, combinational):
  - match[i] = ((src_haddr & MASK_i) == MAP_i) & CONN_MASK[i].
  - sel_a = lowest-index set bit of match (one-hot). Overlapping regions resolve by priority.
  - dec_err_a = (htrans is NONSEQ or SEQ) and match == 0.
- Burst lock registers: burst_active, burst_sel[N_PORTS], burst_err.
  - On an accepted NONSEQ (src_hready and htrans==NONSEQ) with hburst != SINGLE: burst_active <= 1, burst_sel <= sel_a, burst_err <= dec_err_a.
  - An accepted NONSEQ with SINGLE clears burst_active. So does an accepted IDLE.
  - While burst_active, SEQ and BUSY beats use burst_sel and burst_err; address decode is ignored.
- dst_htrans[i] = src_htrans if effective_sel[i], else IDLE. It is forced to IDLE while rst is high.
- Data-phase registers update only when src_hready is high: sel_d <= effective_sel, err_d <= effective_err (BUSY and IDLE beats give err_d = 0).
- Error FSM, states OK, ERR1, ERR2:
  - OK -> ERR1 when err_d is set.
  - ERR1 drives hready_resp=0, hresp=1, then goes to ERR2.
  - ERR2 drives hready_resp=1, hresp=1.
  - From ERR2: next state is ERR1 if a new erroring transfer was accepted in the same cycle; otherwise OK.
- Responses:
  - sel_d != 0: src_hready_resp, src_hresp and src_hrdata are taken from the selected port through a one-hot mux.
  - sel_d == 0 and no error: hready_resp=1, hresp=0, hrdata=0.
  - No combinational path from src_htrans or src_haddr to src_hready_resp.
- Error recording:
  - err_addr <= src_haddr when an erroring transfer is accepted.
  - err_count increments on entry to ERR1 and saturates at all-ones.
  - err_pulse is high in ERR2.
- Master cancels a burst after ERROR by issuing IDLE: the lock clears and the remaining beats are not issued.
- Reset values: burst_active=0, sel_d=0, err_d=0, FSM=OK, err_count=0, err_addr=0, err_pulse=0. Outputs: src_hready_resp=1, src_hresp=0, all dst_htrans=IDLE.
- Reset mid-burst discards the lock. A following SEQ is decoded by address as if it were unlocked.
- Latency: zero added wait states for mapped slaves; exactly one wait plus the ERROR cycle for decode errors.

Decomposition:
- Shared header ahbl_defs.vh holds HTRANS_IDLE/BUSY/NONSEQ/SEQ, HBURST_SINGLE and the error FSM state encodings.
- Sub-modules: reuse onehot_mux for hrdata/hresp/hready_resp selection, and add ahbl_priority_sel (lowest-set-bit one-hot picker).

Test Plan:
Setup: N_PORTS=2; port0 MAP 0x20000000, MASK 0xF0000000; port1 MAP 0x40000000, MASK 0xF0000000.
1. SINGLE read of 0x20000010 with slave0 returning 0xDEADBEEF -> src_hrdata=0xDEADBEEF, hresp=0, dst_htrans[3:2] stays IDLE.
2. INCR4 from 0x2FFFFFF8 (beats 3 and 4 land at 0x30000000+) -> all 4 beats go to port0, port1 htrans IDLE throughout, no error.
3. Read of 0x80000000 -> hready_resp/hresp = 0/1 then 1/1; err_count=1; err_addr=0x80000000; err_pulse high one cycle.
4. CONN_MASK=2'b01, read of 0x40000000 -> ERROR response, port1 never sees NONSEQ. Separately, set MAP1=0x20000000 (overlap) -> access routes to port0.
5. Slave0 inserts 3 wait states, then hresp ERROR -> src_hready_resp low for 3 cycles, ERROR passed through. Master IDLE after the error clears the lock.
6. Assert rst during beat 2 of INCR8 -> next cycle all dst_htrans IDLE, err_count=0, src_hready_resp=1. Following SEQ to 0x40000004 is routed to port1.

Source files
------------

// File: rtl/ahbl_splitter_burst_pkg.sv
// ahbl_splitter_burst_pkg
// Shared AHB-lite encodings and error-FSM states for the burst-aware splitter.
//   HTRANS_* : transfer-type encodings
//   HBURST_SINGLE : the only burst type that does not arm the burst lock
//   err_state_e : decode-error response FSM (OK -> ERR1 -> ERR2)
package ahbl_splitter_burst_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } err_state_e;

endpackage

// File: rtl/ahbl_splitter_burst_if.sv
// ahbl_splitter_burst_if
// Bus bundle between one AHB-lite master and N slave ports.
//   src_* : master-side bus (address/control/wdata in, hready_resp/hresp/hrdata out)
//   dst_* : per-port slave-side bus, packed [N_PORTS-1:0][field]
// Modports:
//   slave  : the splitter's view (it is the master's slave)
//   master : the environment's view (drives src_*, returns dst_* responses)
interface ahbl_splitter_burst_if #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
);
  logic                             src_hready;
  logic                             src_hready_resp;
  logic                             src_hresp;
  logic [W_ADDR-1:0]                src_haddr;
  logic                             src_hwrite;
  logic [1:0]                       src_htrans;
  logic [2:0]                       src_hsize;
  logic [2:0]                       src_hburst;
  logic [3:0]                       src_hprot;
  logic                             src_hmastlock;
  logic [W_DATA-1:0]                src_hwdata;
  logic [W_DATA-1:0]                src_hrdata;

  logic [N_PORTS-1:0]               dst_hready;
  logic [N_PORTS-1:0]               dst_hready_resp;
  logic [N_PORTS-1:0]               dst_hresp;
  logic [N_PORTS-1:0][W_ADDR-1:0]   dst_haddr;
  logic [N_PORTS-1:0]               dst_hwrite;
  logic [N_PORTS-1:0][1:0]          dst_htrans;
  logic [N_PORTS-1:0][2:0]          dst_hsize;
  logic [N_PORTS-1:0][2:0]          dst_hburst;
  logic [N_PORTS-1:0][3:0]          dst_hprot;
  logic [N_PORTS-1:0]               dst_hmastlock;
  logic [N_PORTS-1:0][W_DATA-1:0]   dst_hwdata;
  logic [N_PORTS-1:0][W_DATA-1:0]   dst_hrdata;

  modport slave (
    input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
    output src_hready_resp, src_hresp, src_hrdata,
    output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata,
    input  dst_hready_resp, dst_hresp, dst_hrdata
  );

  modport master (
    output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize, src_hburst,
           src_hprot, src_hmastlock, src_hwdata,
    input  src_hready_resp, src_hresp, src_hrdata,
    input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize, dst_hburst,
           dst_hprot, dst_hmastlock, dst_hwdata,
    output dst_hready_resp, dst_hresp, dst_hrdata
  );

endinterface

// File: rtl/ahbl_priority_sel.sv
// ahbl_priority_sel
// Lowest-set-bit one-hot picker; overlapping address regions resolve to the
// lowest port index.
//   req : request vector
//   gnt : one-hot (or zero) grant
module ahbl_priority_sel #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  // Two's complement isolates the lowest set bit.
  assign gnt = req & (~req + N'(1));
endmodule

// File: rtl/onehot_mux.sv
// onehot_mux
// AND-OR multiplexer for a one-hot select; all-zero select yields zero.
//   sel  : one-hot select
//   din  : packed inputs, one word per select bit
//   dout : selected word
module onehot_mux #(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic [N-1:0]        sel,
  input  logic [N-1:0][W-1:0] din,
  output logic [W-1:0]        dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) dout = dout | (din[i] & {W{sel[i]}});
  end
endmodule

// File: rtl/ahbl_splitter_burst.sv
// ahbl_splitter_burst
// AHB-lite 1:N splitter. Decodes the address phase to a slave port, pins all
// beats of a burst to the port that took its NONSEQ beat, and answers
// unmapped/unconnected transfers with the two-cycle ERROR response.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : master + per-port slave bus (slave modport)
//   err_count : saturating count of decode errors
//   err_addr  : address of the most recent decode error
//   err_pulse : high during the second ERROR cycle
module ahbl_splitter_burst
  import ahbl_splitter_burst_pkg::*;
#(
  parameter int                          N_PORTS   = 2,
  parameter int                          W_ADDR    = 32,
  parameter int                          W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0]   ADDR_MASK = '0,
  parameter logic [N_PORTS-1:0]          CONN_MASK = '1,
  parameter int                          W_ERRCNT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ahbl_splitter_burst_if.slave bus,
  output logic [W_ERRCNT-1:0]  err_count,
  output logic [W_ADDR-1:0]    err_addr,
  output logic                 err_pulse
);

  logic [N_PORTS-1:0]              match, sel_a, eff_sel, sel_d, burst_sel;
  logic                            dec_err_a, lock_use, eff_err, err_acc;
  logic                            burst_active, burst_err, err_d;
  logic [N_PORTS-1:0][W_DATA+1:0]  resp_in;
  logic [W_DATA+1:0]               resp_out;
  err_state_e                      state, state_nxt;

  // Address decode per port.
  for (genvar i = 0; i < N_PORTS; i++) begin : g_dec
    localparam logic [W_ADDR-1:0] MAP = ADDR_MAP[i*W_ADDR +: W_ADDR];
    localparam logic [W_ADDR-1:0] MSK = ADDR_MASK[i*W_ADDR +: W_ADDR];
    assign match[i] = ((bus.src_haddr & MSK) == MAP) && CONN_MASK[i];
  end

  ahbl_priority_sel #(.N(N_PORTS)) u_pick (.req(match), .gnt(sel_a));

  // htrans[1] is set for NONSEQ and SEQ only.
  assign dec_err_a = bus.src_htrans[1] && (match == '0);

  // Inside a burst, SEQ/BUSY follow the NONSEQ's decision regardless of address,
  // so a burst crossing a region boundary stays on one port.
  assign lock_use = burst_active &&
                    (bus.src_htrans == HTRANS_SEQ || bus.src_htrans == HTRANS_BUSY);
  assign eff_sel  = lock_use ? burst_sel : sel_a;
  assign eff_err  = (lock_use ? burst_err : dec_err_a) && bus.src_htrans[1];
  assign err_acc  = bus.src_hready && eff_err;

  // Fan-out to slave ports.
  assign bus.dst_hready    = {N_PORTS{bus.src_hready}};
  assign bus.dst_haddr     = {N_PORTS{bus.src_haddr}};
  assign bus.dst_hwrite    = {N_PORTS{bus.src_hwrite}};
  assign bus.dst_hsize     = {N_PORTS{bus.src_hsize}};
  assign bus.dst_hburst    = {N_PORTS{bus.src_hburst}};
  assign bus.dst_hprot     = {N_PORTS{bus.src_hprot}};
  assign bus.dst_hmastlock = {N_PORTS{bus.src_hmastlock}};
  assign bus.dst_hwdata    = {N_PORTS{bus.src_hwdata}};

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      bus.dst_htrans[i] = (!rst && eff_sel[i]) ? bus.src_htrans : HTRANS_IDLE;
      resp_in[i]        = {bus.dst_hready_resp[i], bus.dst_hresp[i], bus.dst_hrdata[i]};
    end
  end

  // Burst lock, data-phase select and error recording.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_active <= 1'b0;
      burst_sel    <= '0;
      burst_err    <= 1'b0;
      sel_d        <= '0;
      err_d        <= 1'b0;
      err_addr     <= '0;
      err_count    <= '0;
      err_pulse    <= 1'b0;
    end else begin
      if (bus.src_hready) begin
        sel_d <= eff_sel;
        err_d <= eff_err;
        if (bus.src_htrans == HTRANS_NONSEQ) begin
          burst_active <= (bus.src_hburst != HBURST_SINGLE);
          burst_sel    <= sel_a;
          burst_err    <= dec_err_a;
        end else if (bus.src_htrans == HTRANS_IDLE) begin
          burst_active <= 1'b0;
        end
        if (eff_err) err_addr <= bus.src_haddr;
      end
      if (state_nxt == ST_ERR1 && state != ST_ERR1 && err_count != '1)
        err_count <= err_count + 1'b1;
      err_pulse <= (state_nxt == ST_ERR2);
    end
  end

  // Error FSM. It enters ERR1 on the same edge that accepts the erroring
  // transfer, so the first data-phase cycle is already the wait cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_OK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_OK:   if (err_acc) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = err_acc ? ST_ERR1 : ST_OK;
      default: state_nxt = ST_OK;
    endcase
  end

  // Response path depends on registered state and slave responses only.
  onehot_mux #(.N(N_PORTS), .W(W_DATA + 2)) u_rmux (
    .sel (sel_d),
    .din (resp_in),
    .dout(resp_out)
  );

  always_comb begin
    bus.src_hready_resp = 1'b1;
    bus.src_hresp       = 1'b0;
    bus.src_hrdata      = resp_out[W_DATA-1:0];
    if (err_d) begin
      // err_d is set exactly while the FSM is in ERR1/ERR2.
      bus.src_hready_resp = (state == ST_ERR2);
      bus.src_hresp       = 1'b1;
    end else if (|sel_d) begin
      bus.src_hready_resp = resp_out[W_DATA+1];
      bus.src_hresp       = resp_out[W_DATA];
    end
  end

endmodule

// File: tb/tb_ahbl_splitter_burst.sv
// tb_ahbl_splitter_burst
// Directed bench. Three splitters share one stimulus stream:
//   0 : standard map (port0 0x2xxxxxxx, port1 0x4xxxxxxx)
//   1 : standard map, port1 unconnected
//   2 : both ports mapped to 0x2xxxxxxx (overlap)
// Each splitter's hready is looped back from its own hready_resp.
module tb_ahbl_splitter_burst;
  import ahbl_splitter_burst_pkg::*;

  localparam int NP = 2;
  localparam int WA = 32;
  localparam int WD = 32;
  localparam logic [NP*WA-1:0] MAP_STD = {32'h4000_0000, 32'h2000_0000};
  localparam logic [NP*WA-1:0] MAP_OVL = {32'h2000_0000, 32'h2000_0000};
  localparam logic [NP*WA-1:0] MSK     = {32'hF000_0000, 32'hF000_0000};
  localparam logic [2:0][NP*WA-1:0] MAPS  = {MAP_OVL, MAP_STD, MAP_STD};
  localparam logic [2:0][NP-1:0]    CONNS = {2'b11, 2'b01, 2'b11};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]          haddr;
  logic [1:0]           htrans;
  logic [2:0]           hburst;
  logic [NP-1:0]        s_rdy, s_resp;
  logic [NP-1:0][31:0]  s_rdata;

  logic [2:0]                rdy, rsp, epls;
  logic [2:0][31:0]          rdata, eaddr;
  logic [2:0][7:0]           ecnt;
  logic [2:0][NP-1:0][1:0]   dtr;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    ahbl_splitter_burst_if #(.N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD)) bus ();
    assign bus.src_hready      = bus.src_hready_resp;
    assign bus.src_haddr       = haddr;
    assign bus.src_hwrite      = 1'b0;
    assign bus.src_htrans      = htrans;
    assign bus.src_hsize       = 3'b010;
    assign bus.src_hburst      = hburst;
    assign bus.src_hprot       = 4'b0011;
    assign bus.src_hmastlock   = 1'b0;
    assign bus.src_hwdata      = '0;
    assign bus.dst_hready_resp = s_rdy;
    assign bus.dst_hresp       = s_resp;
    assign bus.dst_hrdata      = s_rdata;
    assign rdy[k]   = bus.src_hready_resp;
    assign rsp[k]   = bus.src_hresp;
    assign rdata[k] = bus.src_hrdata;
    assign dtr[k]   = bus.dst_htrans;

    ahbl_splitter_burst #(
      .N_PORTS(NP), .W_ADDR(WA), .W_DATA(WD),
      .ADDR_MAP(MAPS[k]), .ADDR_MASK(MSK), .CONN_MASK(CONNS[k]), .W_ERRCNT(8)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .err_count(ecnt[k]),
      .err_addr (eaddr[k]),
      .err_pulse(epls[k])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; haddr = '0; htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
    s_rdy = 2'b11; s_resp = 2'b00; s_rdata = '0;

    // Reset state; htrans forced IDLE while in reset.
    tick(); tick();
    haddr = 32'h2000_0000; htrans = HTRANS_NONSEQ; #1;
    chk("rst_dtr0", dtr[0][0], HTRANS_IDLE);
    chk("rst_rdy", rdy[0], 1'b1);
    chk("rst_rsp", rsp[0], 1'b0);
    chk("rst_ecnt", ecnt[0], 8'd0);
    chk("rst_eaddr", eaddr[0], 32'h0);
    chk("rst_epls", epls[0], 1'b0);
    rst = 1'b0; htrans = HTRANS_IDLE;
    tick();

    // 1: SINGLE read to port0.
    haddr = 32'h2000_0010; htrans = HTRANS_NONSEQ; hburst = HBURST_SINGLE; #1;
    chk("t1_dtr0", dtr[0][0], HTRANS_NONSEQ);
    chk("t1_dtr1", dtr[0][1], HTRANS_IDLE);
    tick();
    htrans = HTRANS_IDLE; s_rdata[0] = 32'hDEAD_BEEF; #1;
    chk("t1_rdata", rdata[0], 32'hDEAD_BEEF);
    chk("t1_rsp", rsp[0], 1'b0);
    chk("t1_rdy", rdy[0], 1'b1);
    chk("t1_dtr1_dp", dtr[0][1], HTRANS_IDLE);

    // 2: INCR4 crossing into unmapped 0x3xxxxxxx stays on port0.
    hburst = 3'b011;
    for (int b = 0; b < 4; b++) begin
      tick();
      haddr  = 32'h2FFF_FFF8 + 32'(4 * b);
      htrans = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ; #1;
      chk($sformatf("t2_dtr0_b%0d", b), dtr[0][0], (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
      chk($sformatf("t2_dtr1_b%0d", b), dtr[0][1], HTRANS_IDLE);
      chk($sformatf("t2_rsp_b%0d", b), rsp[0], 1'b0);
    end
    tick();
    htrans = HTRANS_IDLE; hburst = HBURST_SINGLE; #1;
    chk("t2_rdy_end", rdy[0], 1'b1);
    chk("t2_rsp_end", rsp[0], 1'b0);
    chk("t2_ecnt", ecnt[0], 8'd0);

    // 3: unmapped read -> wait + ERROR.
    tick();
    haddr = 32'h8000_0000; htrans = HTRANS_NONSEQ; #1;
    chk("t3_dtr0", dtr[0][0], HTRANS_IDLE);
    chk("t3_dtr1", dtr[0][1], HTRANS_IDLE);
    tick();
    htrans = HTRANS_IDLE; #1;
    chk("t3_e1_rdy", rdy[0], 1'b0);
    chk("t3_e1_rsp", rsp[0], 1'b1);
    chk("t3_ecnt", ecnt[0], 8'd1);
    chk("t3_eaddr", eaddr[0], 32'h8000_0000);
    chk("t3_e1_pls", epls[0], 1'b0);
    tick();
    chk("t3_e2_rdy", rdy[0], 1'b1);
    chk("t3_e2_rsp", rsp[0], 1'b1);
    chk("t3_e2_pls", epls[0], 1'b1);
    tick();
    chk("t3_ok_rdy", rdy[0], 1'b1);
    chk("t3_ok_rsp", rsp[0], 1'b0);
    chk("t3_ok_pls", epls[0], 1'b0);
    chk("t3_ecnt_hold", ecnt[0], 8'd1);

    // 4a: unconnected port1 -> ERROR, port1 never sees NONSEQ.
    tick();
    haddr = 32'h4000_0000; htrans = HTRANS_NONSEQ; #1;
    chk("t4_conn_dtr1", dtr[1][1], HTRANS_IDLE);
    chk("t4_std_dtr1", dtr[0][1], HTRANS_NONSEQ);
    tick();
    htrans = HTRANS_IDLE; #1;
    chk("t4_conn_e1_rdy", rdy[1], 1'b0);
    chk("t4_conn_e1_rsp", rsp[1], 1'b1);
    chk("t4_conn_ecnt", ecnt[1], 8'd2);
    chk("t4_std_rdy", rdy[0], 1'b1);
    chk("t4_std_rsp", rsp[0], 1'b0);
    tick();
    chk("t4_conn_e2_rdy", rdy[1], 1'b1);
    chk("t4_conn_e2_rsp", rsp[1], 1'b1);
    tick();
    chk("t4_conn_ok_rsp", rsp[1], 1'b0);
    // 4b: overlapping regions resolve to port0.
    tick();
    haddr = 32'h2000_0020; htrans = HTRANS_NONSEQ; #1;
    chk("t4_ovl_dtr0", dtr[2][0], HTRANS_NONSEQ);
    chk("t4_ovl_dtr1", dtr[2][1], HTRANS_IDLE);
    tick();
    htrans = HTRANS_IDLE; #1;
    chk("t4_ovl_rdy", rdy[2], 1'b1);
    chk("t4_ovl_rsp", rsp[2], 1'b0);

    // 5: slave wait states then slave ERROR; IDLE clears the lock.
    tick();
    haddr = 32'h2000_0100; htrans = HTRANS_NONSEQ; hburst = 3'b011; #1;
    chk("t5_dtr0", dtr[0][0], HTRANS_NONSEQ);
    tick();
    haddr = 32'h2000_0104; htrans = HTRANS_SEQ; s_rdy[0] = 1'b0; s_resp[0] = 1'b0; #1;
    chk("t5_w0_rdy", rdy[0], 1'b0);
    for (int w = 1; w < 3; w++) begin
      tick();
      chk($sformatf("t5_w%0d_rdy", w), rdy[0], 1'b0);
      chk($sformatf("t5_w%0d_rsp", w), rsp[0], 1'b0);
    end
    tick();
    s_resp[0] = 1'b1; htrans = HTRANS_IDLE; #1;
    chk("t5_e1_rdy", rdy[0], 1'b0);
    chk("t5_e1_rsp", rsp[0], 1'b1);
    chk("t5_e1_dtr0", dtr[0][0], HTRANS_IDLE);
    tick();
    s_rdy[0] = 1'b1; #1;
    chk("t5_e2_rdy", rdy[0], 1'b1);
    chk("t5_e2_rsp", rsp[0], 1'b1);
    tick();
    s_resp[0] = 1'b0; haddr = 32'h4000_0000; htrans = HTRANS_SEQ; #1;
    chk("t5_unlock_dtr1", dtr[0][1], HTRANS_SEQ);
    chk("t5_unlock_dtr0", dtr[0][0], HTRANS_IDLE);
    chk("t5_ecnt", ecnt[0], 8'd1);
    htrans = HTRANS_IDLE;

    // 6: reset during beat 2 of INCR8 drops the lock.
    tick();
    haddr = 32'h2000_0200; htrans = HTRANS_NONSEQ; hburst = 3'b101; #1;
    chk("t6_dtr0", dtr[0][0], HTRANS_NONSEQ);
    tick();
    haddr = 32'h2000_0204; htrans = HTRANS_SEQ; rst = 1'b1; #1;
    chk("t6_rst_dtr0", dtr[0][0], HTRANS_IDLE);
    chk("t6_rst_dtr1", dtr[0][1], HTRANS_IDLE);
    tick();
    rst = 1'b0; haddr = 32'h4000_0004; #1;
    chk("t6_seq_dtr1", dtr[0][1], HTRANS_SEQ);
    chk("t6_seq_dtr0", dtr[0][0], HTRANS_IDLE);
    chk("t6_ecnt", ecnt[0], 8'd0);
    chk("t6_rdy", rdy[0], 1'b1);
    chk("t6_rsp", rsp[0], 1'b0);
    tick();
    htrans = HTRANS_IDLE; hburst = HBURST_SINGLE;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
